// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF race controller.
package puf_pkg;

    localparam int unsigned DefRespBits = 8;
    localparam int unsigned DefSelW     = 4;
    localparam int unsigned DefTimeoutW = 20;

    // Response bit recorded when both finish flags rise in the same cycle.
    localparam logic TieBit = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StClear0,
        StClear1,
        StRace,
        StRecord,
        StDone
    } state_e;

endpackage

// File: rtl/puf_race_timer.sv
// Race watchdog: counts enabled cycles and flags the cycle that brings the count to all-ones.
module puf_race_timer #(
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LastCount = {TIMEOUT_W{1'b1}} - 1'b1;

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The enabled cycle seeing LastCount is the (2^W-1)-th race cycle.
    assign expired_o = (count_q == LastCount);

endmodule

// File: rtl/puf_race_ctrl.sv
// Sequences one oscillator-pair race per response bit and hands the response word out via
// a valid/ack handshake. All outputs are registered from the next-state values.
module puf_race_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned RESP_BITS = DefRespBits,
    parameter int unsigned SEL_W     = DefSelW,
    parameter int unsigned TIMEOUT_W = DefTimeoutW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [RESP_BITS*SEL_W-1:0] challenge,
    input  logic                       done_a,
    input  logic                       done_b,
    output logic [SEL_W-1:0]           pair_sel,
    output logic                       ro_en,
    output logic                       ctr_clr,
    output logic [RESP_BITS-1:0]       response,
    output logic                       resp_valid,
    input  logic                       resp_ack,
    output logic                       busy,
    output logic                       tie,
    output logic                       timeout
);

    localparam int unsigned      IdxW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(RESP_BITS - 1);

    state_e                       state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [RESP_BITS*SEL_W-1:0]   chal_q, chal_d;
    logic                         bit_q, bit_d;
    logic [RESP_BITS-1:0]         response_q, response_d;
    logic                         tie_q, tie_d;
    logic                         timeout_q, timeout_d;
    logic [SEL_W-1:0]             pair_sel_q, pair_sel_d;
    logic                         ro_en_q, ro_en_d;
    logic                         ctr_clr_q, ctr_clr_d;
    logic                         resp_valid_q, resp_valid_d;
    logic                         busy_q, busy_d;

    logic timer_clr, timer_en, timer_expired;

    assign timer_clr = (state_q == StClear0) || (state_q == StClear1);
    assign timer_en  = (state_q == StRace);

    puf_race_timer #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        chal_d     = chal_q;
        bit_d      = bit_q;
        response_d = response_q;
        tie_d      = tie_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    chal_d     = challenge;
                    response_d = '0;
                    tie_d      = 1'b0;
                    timeout_d  = 1'b0;
                    idx_d      = '0;
                    state_d    = StClear0;
                end
            end
            StClear0: state_d = StClear1;
            StClear1: state_d = StRace;
            StRace: begin
                // Finish flags take priority over a watchdog expiry in the same cycle.
                if (done_a || done_b) begin
                    state_d = StRecord;
                    if (done_a && done_b) begin
                        bit_d = TieBit;
                        tie_d = 1'b1;
                    end else begin
                        bit_d = done_a;
                    end
                end else if (timer_expired) begin
                    state_d   = StRecord;
                    bit_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            StRecord: begin
                response_d[idx_q] = bit_q;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StClear0;
                end
            end
            StDone: begin
                if (resp_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pair_sel_d = pair_sel_q;
        if (state_d == StClear0) begin
            pair_sel_d = chal_d[int'(idx_d)*SEL_W +: SEL_W];
        end
        ro_en_d      = (state_d == StRace);
        ctr_clr_d    = (state_d == StClear0) || (state_d == StClear1);
        resp_valid_d = (state_d == StDone);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            chal_q       <= '0;
            bit_q        <= 1'b0;
            response_q   <= '0;
            tie_q        <= 1'b0;
            timeout_q    <= 1'b0;
            pair_sel_q   <= '0;
            ro_en_q      <= 1'b0;
            ctr_clr_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            chal_q       <= chal_d;
            bit_q        <= bit_d;
            response_q   <= response_d;
            tie_q        <= tie_d;
            timeout_q    <= timeout_d;
            pair_sel_q   <= pair_sel_d;
            ro_en_q      <= ro_en_d;
            ctr_clr_q    <= ctr_clr_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign pair_sel   = pair_sel_q;
    assign ro_en      = ro_en_q;
    assign ctr_clr    = ctr_clr_q;
    assign response   = response_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign tie        = tie_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Directed bench for puf_race_ctrl with a behavioural model of the two threshold counters.
module tb_puf_race_ctrl;

    localparam int unsigned RB = 8;
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [RB*SW-1:0]  challenge = '0;
    logic              done_a = 1'b0;
    logic              done_b = 1'b0;
    logic              resp_ack = 1'b0;
    logic [SW-1:0]     pair_sel;
    logic              ro_en, ctr_clr, resp_valid, busy, tie, timeout;
    logic [RB-1:0]     response;
    logic [17:0]       all_outs;

    int checks = 0;
    int errors = 0;

    // Counter model configuration: 0 = A wins, 1 = B wins, 2 = tie, 3 = no flag.
    int            win_cfg [RB];
    int            dly_cfg [RB];
    int            race_cycles [RB];
    logic [SW-1:0] sel_log [RB];
    int            race_num = -1;
    int            mcnt = 0;
    int            sel_err = 0;
    logic          prev_clr = 1'b0;

    puf_race_ctrl #(
        .RESP_BITS(RB),
        .SEL_W    (SW),
        .TIMEOUT_W(TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .challenge (challenge),
        .done_a    (done_a),
        .done_b    (done_b),
        .pair_sel  (pair_sel),
        .ro_en     (ro_en),
        .ctr_clr   (ctr_clr),
        .response  (response),
        .resp_valid(resp_valid),
        .resp_ack  (resp_ack),
        .busy      (busy),
        .tie       (tie),
        .timeout   (timeout)
    );

    assign all_outs = {busy, ro_en, ctr_clr, resp_valid, tie, timeout, response, pair_sel};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_a   = 1'b0;
            done_b   = 1'b0;
            mcnt     = 0;
            prev_clr = 1'b0;
        end else begin
            if (ctr_clr) begin
                if (!prev_clr) begin
                    race_num++;
                    if (race_num >= 0 && race_num < RB) sel_log[race_num] = pair_sel;
                end
                done_a = 1'b0;
                done_b = 1'b0;
                mcnt   = 0;
            end else if (ro_en && race_num >= 0 && race_num < RB) begin
                mcnt++;
                race_cycles[race_num] = mcnt;
                if (mcnt > dly_cfg[race_num]) begin
                    case (win_cfg[race_num])
                        0: done_a = 1'b1;
                        1: done_b = 1'b1;
                        2: begin done_a = 1'b1; done_b = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if (race_num >= 0 && race_num < RB && (ctr_clr || ro_en) &&
                pair_sel !== sel_log[race_num]) sel_err++;
            prev_clr = ctr_clr;
        end
    end

    task automatic cfg_all(input int w, input int d);
        for (int i = 0; i < RB; i++) begin
            win_cfg[i] = w;
            dly_cfg[i] = d;
        end
    endtask

    // Returns at the falling edge after the start edge; challenge is scrambled afterwards.
    task automatic do_start(input logic [RB*SW-1:0] ch);
        race_num = -1;
        sel_err  = 0;
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        challenge = '1;
    endtask

    task automatic wait_valid(input int start_cnt, output int cycles);
        cycles = start_cnt;
        while (resp_valid !== 1'b1 && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        resp_ack = 1'b1;
        @(posedge clk);
        #1;
        resp_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pure_wins();
        int cyc;
        for (int i = 0; i < RB; i++) begin
            win_cfg[i] = i % 2;
            dly_cfg[i] = i % 3;
        end
        do_start(32'h7654_3210);
        wait_valid(0, cyc);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pure_valid: got %b expected 1", resp_valid);
        end
        checks++;
        if (response !== 8'h55) begin
            errors++;
            $display("FAIL pure_response: got %h expected 55", response);
        end
        checks++;
        if ({tie, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL pure_flags: got %b expected 00", {tie, timeout});
        end
        for (int i = 0; i < RB; i++) begin
            checks++;
            if (sel_log[i] !== SW'(i)) begin
                errors++;
                $display("FAIL pure_pair_sel%0d: got %h expected %h", i, sel_log[i], SW'(i));
            end
        end
        checks++;
        if (sel_err !== 0) begin
            errors++;
            $display("FAIL pure_sel_stable: got %0d changes expected 0", sel_err);
        end
        do_ack();
    endtask

    task automatic test_tie();
        int cyc;
        cfg_all(0, 1);
        win_cfg[3] = 2;
        dly_cfg[3] = 2;
        do_start(32'hFEDC_BA98);
        wait_valid(0, cyc);
        checks++;
        if (response !== 8'hF7) begin
            errors++;
            $display("FAIL tie_response: got %h expected f7", response);
        end
        checks++;
        if ({tie, timeout} !== 2'b10) begin
            errors++;
            $display("FAIL tie_flags: got %b expected 10", {tie, timeout});
        end
        checks++;
        if (sel_log[3] !== 4'hB) begin
            errors++;
            $display("FAIL tie_pair_sel3: got %h expected b", sel_log[3]);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        int cyc;
        cfg_all(0, 0);
        win_cfg[0] = 3;
        do_start(32'h0123_4567);
        wait_valid(0, cyc);
        checks++;
        if (response !== 8'hFE) begin
            errors++;
            $display("FAIL tmo_response: got %h expected fe", response);
        end
        checks++;
        if ({tie, timeout} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_flags: got %b expected 01", {tie, timeout});
        end
        checks++;
        if (race_cycles[0] !== 15) begin
            errors++;
            $display("FAIL tmo_race0_len: got %0d expected 15", race_cycles[0]);
        end
        checks++;
        if (race_cycles[1] !== 1) begin
            errors++;
            $display("FAIL tmo_race1_len: got %0d expected 1", race_cycles[1]);
        end
        do_ack();
    endtask

    task automatic test_handshake();
        int cyc;
        cfg_all(0, 0);
        do_start(32'h0000_0000);
        wait_valid(0, cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = (k == 4);
            checks++;
            if ({resp_valid, busy, ctr_clr, response} !== {3'b110, 8'hFF}) begin
                errors++;
                $display("FAIL hs_hold%0d: got %b/%h expected 110/ff",
                         k, {resp_valid, busy, ctr_clr}, response);
            end
        end
        start = 1'b0;
        do_ack();
        checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL hs_ack_idle: got %b expected 00", {busy, resp_valid});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ctr_clr} !== 2'b00) begin
            errors++;
            $display("FAIL hs_start_ignored: got %b expected 00", {busy, ctr_clr});
        end
    endtask

    task automatic test_latency();
        int cyc;
        cfg_all(0, 0);
        resp_ack = 1'b1;
        do_start(32'hCAFE_F00D);
        checks++;
        if ({ctr_clr, ro_en, pair_sel} !== {2'b10, 4'hD}) begin
            errors++;
            $display("FAIL lat_n1: got %b/%h expected 10/d", {ctr_clr, ro_en}, pair_sel);
        end
        @(negedge clk);
        checks++;
        if ({ctr_clr, ro_en} !== 2'b10) begin
            errors++;
            $display("FAIL lat_n2: got %b expected 10", {ctr_clr, ro_en});
        end
        @(negedge clk);
        checks++;
        if ({ctr_clr, ro_en} !== 2'b01) begin
            errors++;
            $display("FAIL lat_n3: got %b expected 01", {ctr_clr, ro_en});
        end
        @(negedge clk);
        checks++;
        if ({ctr_clr, ro_en} !== 2'b00) begin
            errors++;
            $display("FAIL lat_record: got %b expected 00", {ctr_clr, ro_en});
        end
        wait_valid(3, cyc);
        checks++;
        if (cyc !== 32) begin
            errors++;
            $display("FAIL lat_cycles: got %0d expected 32", cyc);
        end
        checks++;
        if (response !== 8'hFF) begin
            errors++;
            $display("FAIL lat_response: got %h expected ff", response);
        end
        @(posedge clk);
        #1;
        resp_ack = 1'b0;
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL lat_early_ack: got %b expected 00", {resp_valid, busy});
        end
    endtask

    task automatic test_reset_mid_race();
        int n;
        int cyc;
        cfg_all(0, 3);
        win_cfg[1] = 2;
        do_start(32'h0000_0000);
        n = 0;
        while (!(race_num == 3 && ro_en === 1'b1) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ({response, tie, ro_en} !== {8'h05, 2'b11}) begin
            errors++;
            $display("FAIL mid_pre_reset: got %h/%b expected 05/11", response, {tie, ro_en});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0", all_outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RB; i++) begin
            win_cfg[i] = (8'hA5 >> i) & 1 ? 0 : 1;
            dly_cfg[i] = 1;
        end
        do_start(32'h7654_3210);
        wait_valid(0, cyc);
        checks++;
        if (cyc !== 40) begin
            errors++;
            $display("FAIL mid_after_cycles: got %0d expected 40", cyc);
        end
        checks++;
        if ({response, tie, timeout} !== {8'hA5, 2'b00}) begin
            errors++;
            $display("FAIL mid_after_response: got %h/%b expected a5/00",
                     response, {tie, timeout});
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_pure_wins();
        test_tie();
        test_timeout();
        test_handshake();
        test_latency();
        test_reset_mid_race();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_race_ctrl.md
# puf_race_ctrl

Downstream sequencer and arbiter for the ring-oscillator PUF datapath. It walks a challenge through `RESP_BITS` oscillator-pair races, one race per response bit. For each race it:
- selects the pair,
- clears the pair's two threshold counters,
- enables the oscillators,
- records which counter raised its finish flag first.

The accumulated response word is presented with a valid/ack handshake to the readout logic.

## Interface
Parameters:
- `RESP_BITS`, 8, number of races = response width
- `SEL_W`, 4, width of the per-race pair select
- `TIMEOUT_W`, 20, width of the race watchdog counter

Ports:
- `clk` in 1: single system clock, also clocks the counters
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin evaluation; sampled only in IDLE
- `challenge` in `RESP_BITS*SEL_W`: pair select for race i is `challenge[i*SEL_W +: SEL_W]`; latched at start
- `done_a` in 1: finish flag of counter A (clk domain, sticky until cleared)
- `done_b` in 1: finish flag of counter B
- `pair_sel` out `SEL_W`: oscillator-pair mux select
- `ro_en` out 1: oscillator enable
- `ctr_clr` out 1: synchronous clear to both counters
- `response` out `RESP_BITS`: response word
- `resp_valid` out 1: response word is valid
- `resp_ack` in 1: consumer accepts the response
- `busy` out 1: high in every state except IDLE
- `tie` out 1: sticky; at least one race ended in a tie
- `timeout` out 1: sticky; at least one race hit the watchdog

## Operation
- States: IDLE, CLEAR0, CLEAR1, RACE, RECORD, DONE.
- IDLE, on `start`=1:
  - latch `challenge`
  - clear `response`, `tie`, `timeout`
  - set bit index `idx`=0
  - go to CLEAR0
- CLEAR0, CLEAR1:
  - `ctr_clr`=1, `ro_en`=0
  - `pair_sel` = slice `idx`
  - watchdog cleared
  - two cycles, so the counters' finish flags are observed low before racing
- RACE:
  - `ro_en`=1, watchdog increments every cycle
  - first cycle with `done_a`|`done_b` decides the bit:
    - `done_a` only → bit=1
    - `done_b` only → bit=0
    - both in the same cycle → bit=0 and `tie` set
  - watchdog reaches all-ones with neither flag set → bit=0 and `timeout` set
  - any of these outcomes → RECORD
- RECORD:
  - `ro_en`=0
  - write the bit to `response[idx]`
  - if `idx`==`RESP_BITS-1` → DONE; else `idx`+1 → CLEAR0
- DONE: `resp_valid`=1; `response` held stable until the cycle `resp_ack`=1, then → IDLE.
- `start` outside IDLE is ignored.
- `challenge` changes after the latch cycle have no effect.
- `pair_sel` is stable from CLEAR0 through RECORD of each race.
- Reset, asynchronous and at any time including mid-race:
  - state = IDLE
  - all outputs 0, including `response` and the sticky flags
  - `idx` = 0, watchdog = 0
- After reset, counters are cleared by the next evaluation's CLEAR phase, not by reset.

## Timing
- All outputs are registered; none combinational from inputs.
- `start` seen at edge n → `ctr_clr` high for cycles n+1 and n+2, `ro_en` high from n+3.
- Flag first high at RACE edge m → RECORD in cycle m+1 (`ro_en` low) → CLEAR0 of the next race in m+2.
- Per-race cost: 2 clear + k race + 1 record cycles, with k ≥ 1.
- Watchdog limit: 2^`TIMEOUT_W`−1 RACE cycles.
- `resp_valid` rises the cycle after the last RECORD.
- `resp_ack` in the same cycle that `resp_valid` first rises is accepted.
- `busy` falls one cycle after the ack edge.
- `resp_ack` outside DONE is ignored.

## Structure
- Package `puf_pkg` holds:
  - the state enum
  - default values of `RESP_BITS`, `SEL_W`, `TIMEOUT_W`
  - the tie-break constant (tie bit = 0)
- Sub-module `puf_race_timer` implements the watchdog: inputs clear and enable; output `expired` when the count is all-ones.
- The FSM, index counter and response register stay in the top module.

## Test plan
- Reset mid-race: assert `rst_n`=0 while in RACE → outputs all 0 immediately, state IDLE; a following `start` produces a full 8-bit evaluation.
- Pure wins: `RESP_BITS`=8; model `done_a` wins on even races and `done_b` on odd races → `response`=8'h55, `tie`=0, `timeout`=0; each `pair_sel` equals its challenge slice (e.g. challenge 32'h76543210 gives `pair_sel` 0..7 in order).
- Tie: both flags rise in the same cycle on race 3, `done_a` wins all other races → `response`=8'hF7, `tie`=1.
- Timeout: `TIMEOUT_W`=4; no flags on race 0, `done_a` wins the rest → race 0 lasts 15 RACE cycles, `response`=8'hFE, `timeout`=1.
- Handshake:
  - hold `resp_ack`=0 for 10 cycles → `response` and `resp_valid` stable
  - pulse `start` during DONE → no effect
  - `resp_ack`=1 → IDLE next cycle, `busy`=0
- Latency check: a flag asserted on the first RACE cycle → exactly 4 cycles per race, 32 cycles from `start` to `resp_valid` for 8 bits.
